// File: rtl/mem_stage_wait_ctrl_if.sv
// Handshake/bus bundle between the EXE register, the MEM stage and the WB mux.
// master: upstream side (drives the *_in fields, observes ready and MEM/WB outputs)
// slave : MEM stage (consumes *_in fields, drives ready and MEM/WB outputs)
//   wb_en_in, mem_r_en_in, mem_w_en_in  control from EXE register
//   alu_res_in, val_rm_in, dest_in      address/result, store data, dest reg
//   ready                               1 = pipeline may advance
//   wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out  MEM/WB register
//   err_out                             sticky out-of-range flag
interface mem_stage_wait_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              wb_en_in;
  logic              mem_r_en_in;
  logic              mem_w_en_in;
  logic [DATA_W-1:0] alu_res_in;
  logic [DATA_W-1:0] val_rm_in;
  logic [3:0]        dest_in;

  logic              ready;
  logic              wb_en_out;
  logic              mem_r_en_out;
  logic [DATA_W-1:0] alu_res_out;
  logic [DATA_W-1:0] mem_data_out;
  logic [3:0]        dest_out;
  logic              err_out;

  modport master (
    output wb_en_in, mem_r_en_in, mem_w_en_in, alu_res_in, val_rm_in, dest_in,
    input  ready, wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out, err_out
  );

  modport slave (
    input  wb_en_in, mem_r_en_in, mem_w_en_in, alu_res_in, val_rm_in, dest_in,
    output ready, wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out, err_out
  );
endinterface

// File: rtl/mem_stage_wait_ctrl.sv
// MEM stage with multi-cycle (wait-state) data memory plus the MEM/WB register.
// A load/store stalls the pipeline (ready=0) for WAIT_CYCLES+1 cycles, then
// presents one ready=1 cycle in which the MEM/WB register captures the result.
// Non-memory ops pass straight through with no stall.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (memory array is never cleared)
//   bus  mem_stage_wait_ctrl_if.slave: EXE-side inputs, ready, MEM/WB outputs
// Optional feature macro: MEM_RANGE_CHECK_EN
//   defined  : out-of-range accesses suppress stores, read 0, set sticky err_out
//   undefined: addresses wrap modulo DEPTH, err_out tied 0
module mem_stage_wait_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stage_wait_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [DATA_W-1:0] BASE     = DATA_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e            state_q, state_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              req_c;
  logic              ready_c;
  logic              commit_c;
  logic              oor_c;
  logic [DATA_W-1:0] offset_c;
  logic [IDX_W-1:0]  idx_c;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_c;

  logic              wb_en_q;
  logic              mem_r_en_q;
  logic [DATA_W-1:0] alu_res_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [3:0]        dest_q;

  // Request decode and word index (low two address bits dropped, upper bits wrap)
  assign req_c    = bus.mem_r_en_in | bus.mem_w_en_in;
  assign offset_c = bus.alu_res_in - BASE;
  assign idx_c    = IDX_W'(offset_c >> 2);

  // Optional range check with sticky error flag
`ifdef MEM_RANGE_CHECK_EN
  logic err_q;

  assign oor_c = (bus.alu_res_in < BASE) || ((offset_c >> 2) >= DATA_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (commit_c && oor_c) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_out = err_q;
`else
  assign oor_c       = 1'b0;
  assign bus.err_out = 1'b0;
`endif

  // FSM state and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Next state, stall and commit strobe
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    ready_c  = 1'b1;
    commit_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          ready_c  = 1'b0;
          cnt_nx   = CNT_LOAD;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        ready_c = 1'b0;
        if (cnt_q == '0) begin
          commit_c = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.ready = ready_c;

  // Memory array; gated by rst so a reset on the final wait cycle drops the store
  always_ff @(posedge clk) begin
    if (!rst && commit_c && bus.mem_w_en_in && !oor_c) begin
      mem[idx_c] <= bus.val_rm_in;
    end
  end

  // Read data latched at commit; a combined r/w returns the written value
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (commit_c) begin
      if (oor_c) begin
        rdata_q <= '0;
      end else if (bus.mem_w_en_in) begin
        rdata_q <= bus.mem_r_en_in ? bus.val_rm_in : '0;
      end else begin
        rdata_q <= mem[idx_c];
      end
    end
  end

  // Only the DONE cycle carries a memory result; pass-through ops read as 0
  assign rdata_c = (state_q == DONE) ? rdata_q : '0;

  // MEM/WB register: capture on ready, insert bubble while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      dest_q     <= '0;
    end else if (ready_c) begin
      wb_en_q    <= bus.wb_en_in;
      mem_r_en_q <= bus.mem_r_en_in;
      alu_res_q  <= bus.alu_res_in;
      mem_data_q <= rdata_c;
      dest_q     <= bus.dest_in;
    end else begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
    end
  end

  assign bus.wb_en_out    = wb_en_q;
  assign bus.mem_r_en_out = mem_r_en_q;
  assign bus.alu_res_out  = alu_res_q;
  assign bus.mem_data_out = mem_data_q;
  assign bus.dest_out     = dest_q;

endmodule

// File: tb/tb_mem_stage_wait_ctrl.sv
// Randomized self-checking bench for mem_stage_wait_ctrl against a
// transaction-level reference (word array, stall length per op).
module tb_mem_stage_wait_ctrl;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned DEPTH       = 64;
  localparam int unsigned WAIT_CYCLES = 4;
  localparam int unsigned BASE_ADDR   = 1024;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_stage_wait_ctrl_if #(.DATA_W(DATA_W)) bus ();

  mem_stage_wait_ctrl #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES),
    .BASE_ADDR   (BASE_ADDR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] ref_mem [DEPTH];
  logic        ref_err;
  logic [31:0] ref_alu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.wb_en_in    = 1'b0;
    bus.mem_r_en_in = 1'b0;
    bus.mem_w_en_in = 1'b0;
    bus.alu_res_in  = '0;
    bus.val_rm_in   = '0;
    bus.dest_in     = '0;
  endtask

  // Apply one op (called at a negedge); returns at the negedge after it is accepted
  task automatic do_op(input logic wb, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] v, input logic [3:0] d);
    int unsigned n_stall;
    logic [31:0] off;
    int unsigned idx;
    logic        oor;
    logic [31:0] exp_data;

    bus.wb_en_in    = wb;
    bus.mem_r_en_in = r;
    bus.mem_w_en_in = w;
    bus.alu_res_in  = a;
    bus.val_rm_in   = v;
    bus.dest_in     = d;

    n_stall = (r || w) ? WAIT_CYCLES + 1 : 0;
    for (int i = 0; i <= int'(n_stall); i++) begin
      #1;
      check("ready", 32'(bus.ready), 32'(i == int'(n_stall)));
      @(negedge clk);
      if (i < int'(n_stall)) begin
        check("bubble_wb_en", 32'(bus.wb_en_out), 32'd0);
        check("bubble_mem_r_en", 32'(bus.mem_r_en_out), 32'd0);
        check("hold_alu_res", bus.alu_res_out, ref_alu);
      end
    end

    off = a - BASE_ADDR;
    idx = int'((off >> 2) % DEPTH);
    oor = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
    oor = (a < BASE_ADDR) || ((off >> 2) >= DEPTH);
`endif
    exp_data = '0;
    if (w) begin
      if (!oor) ref_mem[idx] = v;
      if (r && !oor) exp_data = v;
    end else if (r && !oor) begin
      exp_data = ref_mem[idx];
    end
    if ((r || w) && oor) ref_err = 1'b1;
    ref_alu = a;

    check("wb_en_out", 32'(bus.wb_en_out), 32'(wb));
    check("mem_r_en_out", 32'(bus.mem_r_en_out), 32'(r));
    check("alu_res_out", bus.alu_res_out, a);
    check("dest_out", 32'(bus.dest_out), 32'(d));
    check("mem_data_out", bus.mem_data_out, exp_data);
    check("err_out", 32'(bus.err_out), 32'(ref_err));
  endtask

  // Start a store, assert rst during wait cycle k (1..WAIT_CYCLES); store is dropped
  task automatic reset_mid(input logic [31:0] a, input logic [31:0] v, input int unsigned k);
    bus.wb_en_in    = 1'b0;
    bus.mem_r_en_in = 1'b0;
    bus.mem_w_en_in = 1'b1;
    bus.alu_res_in  = a;
    bus.val_rm_in   = v;
    bus.dest_in     = 4'd5;
    repeat (k) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    #1;
    ref_err = 1'b0;
    ref_alu = '0;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_wb_en", 32'(bus.wb_en_out), 32'd0);
    check("rst_mem_r_en", 32'(bus.mem_r_en_out), 32'd0);
    check("rst_alu_res", bus.alu_res_out, 32'd0);
    check("rst_mem_data", bus.mem_data_out, 32'd0);
    check("rst_dest", 32'(bus.dest_out), 32'd0);
    check("rst_err", 32'(bus.err_out), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int unsigned sel;

    rst     = 1'b1;
    ref_err = 1'b0;
    ref_alu = '0;
    set_idle();
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_wb_en", 32'(bus.wb_en_out), 32'd0);
    check("reset_mem_r_en", 32'(bus.mem_r_en_out), 32'd0);
    check("reset_alu_res", bus.alu_res_out, 32'd0);
    check("reset_mem_data", bus.mem_data_out, 32'd0);
    check("reset_dest", 32'(bus.dest_out), 32'd0);
    check("reset_err", 32'(bus.err_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Give every word a known value
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_op(1'b0, 1'b0, 1'b1, BASE_ADDR + 32'(4 * i), $urandom, 4'd0);
    end

    // Store then load at the base address
    do_op(1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 4'd0);
    do_op(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd7);
    // Pure ALU op
    do_op(1'b1, 1'b0, 1'b0, 32'h15, 32'd0, 4'd3);
    // Wrap / range behaviour
    do_op(1'b0, 1'b0, 1'b1, 32'd1024, 32'h11, 4'd0);
    do_op(1'b0, 1'b0, 1'b1, 32'd1280, 32'h22, 4'd0);
    do_op(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd1);
    do_op(1'b1, 1'b1, 1'b0, 32'd1280, 32'd0, 4'd2);
    do_op(1'b1, 1'b1, 1'b0, 32'd1020, 32'd0, 4'd2);
    // Reset in the 2nd wait cycle, then read back the old value
    reset_mid(32'd1028, 32'hAA, 2);
    do_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd4);
    // Back-to-back load and store
    do_op(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd6);
    do_op(1'b0, 1'b0, 1'b1, 32'd1032, 32'h1234, 4'd0);
    // Simultaneous read/write, write-first
    do_op(1'b1, 1'b1, 1'b1, 32'd1036, 32'h5A, 4'd8);
    do_op(1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd9);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE_ADDR + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      if (n % 50 == 49) begin
        reset_mid(a, $urandom, $urandom_range(1, WAIT_CYCLES));
      end else begin
        do_op(1'($urandom_range(0, 1)), (sel >= 3 && sel <= 5) || sel == 9,
              sel >= 6, a, $urandom, 4'($urandom_range(0, 15)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
